// File: rtl/flit_credit_sender.sv
// flit_credit_sender: valid/ready to credit-based send/credit adapter with a 2-entry skid FIFO.
// Define FLIT_CREDIT_SENDER_CHECK_EN to enable the sticky credit_err overflow flag and its assertion.
module flit_credit_sender #(
   parameter int FLIT_WIDTH = 128,
   parameter int DEST_WIDTH = 4,
   parameter int FLIT_BUFFER_DEPTH = 4,
   localparam int CNT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
   input  logic                  clk_noc,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [FLIT_WIDTH-1:0] in_data,
   input  logic [DEST_WIDTH-1:0] in_dest,
   input  logic                  in_is_tail,
   output logic [FLIT_WIDTH-1:0] data_out,
   output logic [DEST_WIDTH-1:0] dest_out,
   output logic                  is_tail_out,
   output logic                  send_out,
   input  logic                  credit_in,
   output logic [CNT_WIDTH-1:0]  credits,
   output logic                  credit_err
);
   localparam int EW = FLIT_WIDTH + DEST_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(FLIT_BUFFER_DEPTH);

   logic [EW-1:0]        mem [2];
   logic [1:0]           occ;
   logic                 rd_ptr, wr_ptr;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 push, send, overflow;

   assign in_ready = ~occ[1];
   assign push     = in_valid & in_ready;
   assign send     = (occ != 2'd0) & (cnt != '0);
   assign overflow = credit_in & ~send & (cnt == FULL);
   assign credits  = cnt;

   always_ff @(posedge clk_noc or negedge rst_n)
      if (!rst_n) begin
         occ         <= 2'd0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         cnt         <= FULL;
         send_out    <= 1'b0;
         data_out    <= '0;
         dest_out    <= '0;
         is_tail_out <= 1'b0;
      end else begin
         occ      <= occ + {1'b0, push} - {1'b0, send};
         send_out <= send;
         if (push) wr_ptr <= ~wr_ptr;
         if (send) begin
            rd_ptr                              <= ~rd_ptr;
            {data_out, dest_out, is_tail_out}   <= mem[rd_ptr];
         end
         // a credit at full count with no send is dropped: the counter saturates
         cnt <= overflow ? cnt : cnt + CNT_WIDTH'(credit_in) - CNT_WIDTH'(send);
      end

   always_ff @(posedge clk_noc)
      if (push) mem[wr_ptr] <= {in_data, in_dest, in_is_tail};

`ifdef FLIT_CREDIT_SENDER_CHECK_EN
   logic err;

   always_ff @(posedge clk_noc or negedge rst_n)
      if (!rst_n) err <= 1'b0;
      else if (overflow) err <= 1'b1;

   assign credit_err = err;

   always_ff @(posedge clk_noc)
      if (rst_n) assert (!overflow);
`else
   assign credit_err = 1'b0;
`endif
endmodule

// File: tb/tb_flit_credit_sender.sv
// tb_flit_credit_sender: directed scoreboard bench for flit_credit_sender (FLIT_BUFFER_DEPTH = 4).
module tb_flit_credit_sender;
   localparam int FW = 128;
   localparam int DW = 4;
   localparam int EW = FW + DW + 1;

   logic          clk_noc = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, in_is_tail, is_tail_out, send_out, credit_in, credit_err;
   logic [FW-1:0] in_data, data_out;
   logic [DW-1:0] in_dest, dest_out;
   logic [2:0]    credits;

   int checks = 0;
   int errors = 0;
   int sends = 0;
   int tails = 0;
   int run = 0;
   logic prev_send = 1'b0;
   logic [EW-1:0] sb [$];

   flit_credit_sender dut (
      .clk_noc(clk_noc), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_dest(in_dest), .in_is_tail(in_is_tail),
      .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
      .send_out(send_out), .credit_in(credit_in), .credits(credits), .credit_err(credit_err)
   );

   always #5 clk_noc = ~clk_noc;

   function automatic logic [EW-1:0] mk(input int id, input logic t);
      logic [31:0] w;
      w = 32'hC0DE_0000 | 32'(id);
      return {{4{w}}, 4'(id * 3 + 1), t};
   endfunction

   task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk_noc);
      #1;
   endtask

   task automatic push(input int id, input logic t);
      tick();
      chk("push_ready", EW'(in_ready), EW'(1));
      in_valid = 1'b1;
      {in_data, in_dest, in_is_tail} = mk(id, t);
      sb.push_back(mk(id, t));
   endtask

   task automatic burst6(input int base);
      for (int i = 0; i < 6; i++) push(base + i, 1'b0);
      tick();
      in_valid = 1'b0;
   endtask

   // scoreboard: every send_out pulse must carry the oldest accepted flit
   always @(negedge clk_noc)
      if (rst_n) begin
         if (send_out) begin
            sends++;
            if (is_tail_out) tails++;
            run = prev_send ? run + 1 : 1;
            if (sb.size() == 0) chk("unexpected_send", EW'(1), EW'(0));
            else chk("send_flit", {data_out, dest_out, is_tail_out}, sb.pop_front());
         end
         prev_send = send_out;
      end else prev_send = 1'b0;

   initial begin
      int s0, t0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      in_dest = '0;
      in_is_tail = 1'b0;
      credit_in = 1'b0;
      repeat (2) @(posedge clk_noc);
      tick();
      chk("rst_send", EW'(send_out), EW'(0));
      chk("rst_data", {data_out, dest_out, is_tail_out}, EW'(0));
      chk("rst_ready", EW'(in_ready), EW'(1));
      chk("rst_credits", EW'(credits), EW'(4));
      chk("rst_err", EW'(credit_err), EW'(0));
      rst_n = 1'b1;

      // stall: 6 flits, no credits returned
      burst6(0);
      tick();
      tick();
      chk("t1_sends", EW'(sends), EW'(4));
      chk("t1_consecutive", EW'(run), EW'(4));
      chk("t1_credits", EW'(credits), EW'(0));
      chk("t1_ready", EW'(in_ready), EW'(0));
      chk("t1_queued", EW'(sb.size()), EW'(2));

      // single credit releases flit 5
      credit_in = 1'b1;
      tick();
      credit_in = 1'b0;
      chk("t2_credit_up", EW'(credits), EW'(1));
      tick();
      chk("t2_send", EW'(send_out), EW'(1));
      chk("t2_credits", EW'(credits), EW'(0));
      chk("t2_sends", EW'(sends), EW'(5));

      // credit returned alongside every send: full throughput
      credit_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push(10 + i, 1'b0);
         if (i > 0) chk("t3_send_every_cycle", EW'(send_out), EW'(1));
         chk("t3_credits_steady", EW'(credits), EW'(1));
      end
      tick();
      in_valid = 1'b0;
      chk("t3_send_every_cycle", EW'(send_out), EW'(1));
      tick();
      credit_in = 1'b0;
      chk("t3_last_send", EW'(send_out), EW'(1));
      chk("t3_credits_end", EW'(credits), EW'(1));
      tick();
      chk("t3_idle", EW'(send_out), EW'(0));
      chk("t3_run", EW'(run), EW'(21));
      chk("t3_drained", EW'(sb.size()), EW'(0));

      // overflow at full credit count
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("t4_credits_reset", EW'(credits), EW'(4));
      credit_in = 1'b1;
      tick();
      credit_in = 1'b0;
      chk("t4_saturate", EW'(credits), EW'(4));
`ifdef FLIT_CREDIT_SENDER_CHECK_EN
      chk("t4_err", EW'(credit_err), EW'(1));
      tick();
      chk("t4_err_sticky", EW'(credit_err), EW'(1));
`else
      chk("t4_err", EW'(credit_err), EW'(0));
      tick();
      chk("t4_err_sticky", EW'(credit_err), EW'(0));
`endif
      chk("t4_credits_hold", EW'(credits), EW'(4));

      // reset mid-packet: 2 queued, credits = 1
      burst6(100);
      tick();
      credit_in = 1'b1;
      tick();
      credit_in = 1'b0;
      chk("t5_credits_pre", EW'(credits), EW'(1));
      chk("t5_queued", EW'(sb.size()), EW'(2));
      rst_n = 1'b0;
      #1;
      chk("t5_send", EW'(send_out), EW'(0));
      chk("t5_data", {data_out, dest_out, is_tail_out}, EW'(0));
      chk("t5_credits", EW'(credits), EW'(4));
      chk("t5_ready", EW'(in_ready), EW'(1));
      chk("t5_err", EW'(credit_err), EW'(0));
      sb.delete();
      tick();
      rst_n = 1'b1;
      s0 = sends;
      repeat (3) tick();
      chk("t5_no_send", EW'(sends), EW'(s0));
      chk("t5_credits_after", EW'(credits), EW'(4));

      // 3-flit packet tail marking
      s0 = sends;
      t0 = tails;
      push(200, 1'b0);
      push(201, 1'b0);
      push(202, 1'b1);
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      chk("t6_sends", EW'(sends - s0), EW'(3));
      chk("t6_tails", EW'(tails - t0), EW'(1));
      chk("t6_tail_last", EW'(is_tail_out), EW'(1));
      chk("t6_drained", EW'(sb.size()), EW'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
